// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: opcodes, FSM states,
// datapath select codes and the per-state control word.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       adrSrc;
        logic       regWrite;
        logic       illegal;
        logic [1:0] resultSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] immSrc;
        aluop_t     aluOp;
    } ctrl_t;

    // Moore control word for a state; only MEMADR needs to know lw vs sw.
    function automatic ctrl_t stateOutputs(input state_t s, input logic isStore);
        ctrl_t c;
        c       = '0;
        c.aluOp = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.memReq    = 1'b1;
                c.adrSrc    = 1'b0;
                c.aluSrcA   = SRCA_PC;
                c.aluSrcB   = SRCB_FOUR;
                c.resultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                c.aluSrcA = SRCA_OLDPC;
                c.aluSrcB = SRCB_IMM;
                c.immSrc  = IMM_B;
            end
            S_MEMADR: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
                c.immSrc  = isStore ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                c.memReq = 1'b1;
                c.adrSrc = 1'b1;
            end
            S_MEMWB: begin
                c.resultSrc = RES_DATA;
                c.regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.memReq   = 1'b1;
                c.memWrite = 1'b1;
                c.adrSrc   = 1'b1;
            end
            S_EXECUTER: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_RS2;
                c.aluOp   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
                c.immSrc  = IMM_I;
                c.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.resultSrc = RES_ALUOUT;
                c.regWrite  = 1'b1;
            end
            S_BEQ: begin
                c.aluSrcA   = SRCA_RS1;
                c.aluSrcB   = SRCB_RS2;
                c.aluOp     = ALUOP_SUB;
                c.resultSrc = RES_ALUOUT;
            end
            S_JAL: begin
                c.aluSrcA   = SRCA_OLDPC;
                c.aluSrcB   = SRCB_FOUR;
                c.resultSrc = RES_ALUOUT;
            end
            S_ERROR: begin
                c.illegal = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic state_t decodeTarget(input logic [6:0] op);
        state_t t;
        case (op)
            OP_LW, OP_SW: t = S_MEMADR;
            OP_R:         t = S_EXECUTER;
            OP_I:         t = S_EXECUTEI;
            OP_BEQ:       t = S_BEQ;
            OP_JAL:       t = S_JAL;
            default:      t = S_ERROR;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: turns the FSM's ALUOp plus instruction fields into an ALU operation.
module mc_aludec
    import riscv_pkg::*;
(
    input  aluop_t     aluOp_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] aluControl_o
);

    // funct7b5 only selects sub for R-type; for I-type it is immediate bits.
    always_comb begin
        aluControl_o = ALU_ADD;
        case (aluOp_i)
            ALUOP_SUB: aluControl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  aluControl_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl_o = ALU_SLT;
                    3'b110:  aluControl_o = ALU_OR;
                    3'b111:  aluControl_o = ALU_AND;
                    default: aluControl_o = ALU_ADD;
                endcase
            end
            default: aluControl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core; sequences the shared memory port,
// ALU and staging registers, waiting on MemReady during fetch and data access.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   inFetch;
    logic   inBeq;
    logic   inJal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = decodeTarget(op);
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_FETCH;
        endcase
    end

    // The control word for the state being entered is registered with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= stateOutputs(S_FETCH, 1'b0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= stateOutputs(state_d, op == OP_SW);
        end
    end

    assign inFetch = (state_q == S_FETCH);
    assign inBeq   = (state_q == S_BEQ);
    assign inJal   = (state_q == S_JAL);

    // Strobes are masked by the reset level so an in-flight access drops at once.
    assign MemReq    = ctrl_q.memReq & reset;
    assign MemWrite  = ctrl_q.memWrite & reset;
    assign RegWrite  = ctrl_q.regWrite & reset;
    assign IRWrite   = inFetch & MemReady & reset;
    assign PCWrite   = reset & ((inFetch & MemReady) | (inBeq & Zero) | inJal);
    assign Illegal   = ctrl_q.illegal;
    assign AdrSrc    = ctrl_q.adrSrc;
    assign ResultSrc = ctrl_q.resultSrc;
    assign ALUSrcA   = ctrl_q.aluSrcA;
    assign ALUSrcB   = ctrl_q.aluSrcB;
    assign ImmSrc    = ctrl_q.immSrc;

    mc_aludec u_aludec (
        .aluOp_i      (ctrl_q.aluOp),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .op5_i        (op[5]),
        .aluControl_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle plans built
// from the instruction rules, compared against the DUT every cycle.
module tb_multicycle_ctrl;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       adrSrc;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] resultSrc;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic [1:0] immSrc;
        logic [2:0] aluCtl;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic  ready;
        logic  zero;
        ctl_t  exp;
        string label;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int    checks = 0;
    int    failures = 0;
    logic  expValid = 1'b0;
    ctl_t  expCtl = '0;
    string expLabel = "";
    ctl_t  actCtl;
    cyc_t  plan[$];
    int    cur = 0;
    logic  pending = 1'b0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    assign actCtl = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};

    // Compare process: every cycle with a planned expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (expValid) begin
            checks++;
            if (actCtl !== expCtl) begin
                failures++;
                $display("[TB] FAIL %s act=%b exp=%b t=%0t", expLabel, actCtl, expCtl, $time);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rndBit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] aluExpect(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (f7 && o[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic pushCyc(input string label, input logic rdy, input logic z, input ctl_t c);
        cyc_t e;
        e.label = label;
        e.ready = rdy;
        e.zero  = z;
        e.exp   = c;
        plan.push_back(e);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, given chosen wait counts.
    task automatic buildPlan(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        ctl_t c;
        plan.delete();
        c = '0; c.memReq = 1; c.resultSrc = 2'b10; c.srcB = 2'b10;
        for (int k = 0; k < fw; k++) pushCyc("FETCH_wait", 1'b0, rndBit(), c);
        c.irWrite = 1; c.pcWrite = 1;
        pushCyc("FETCH", 1'b1, rndBit(), c);
        c = '0; c.srcA = 2'b01; c.srcB = 2'b01; c.immSrc = 2'b10;
        pushCyc("DECODE", rndBit(), rndBit(), c);
        if (o == OPC_LW || o == OPC_SW) begin
            c = '0; c.srcA = 2'b10; c.srcB = 2'b01; c.immSrc = (o == OPC_SW) ? 2'b01 : 2'b00;
            pushCyc("MEMADR", rndBit(), rndBit(), c);
            c = '0; c.memReq = 1; c.adrSrc = 1; c.memWrite = (o == OPC_SW);
            for (int k = 0; k < mw; k++) pushCyc("MEM_wait", 1'b0, rndBit(), c);
            pushCyc("MEM_ready", 1'b1, rndBit(), c);
            if (o == OPC_LW) begin
                c = '0; c.resultSrc = 2'b01; c.regWrite = 1;
                pushCyc("MEMWB", rndBit(), rndBit(), c);
            end
        end else if (o == OPC_R || o == OPC_I) begin
            c = '0; c.srcA = 2'b10; c.srcB = (o == OPC_I) ? 2'b01 : 2'b00;
            c.aluCtl = aluExpect(o, f3, f7);
            pushCyc("EXECUTE", rndBit(), rndBit(), c);
            c = '0; c.regWrite = 1;
            pushCyc("ALUWB", rndBit(), rndBit(), c);
        end else if (o == OPC_BEQ) begin
            c = '0; c.srcA = 2'b10; c.aluCtl = 3'b001; c.pcWrite = z;
            pushCyc("BEQ", rndBit(), z, c);
        end else if (o == OPC_JAL) begin
            c = '0; c.srcA = 2'b01; c.srcB = 2'b10; c.pcWrite = 1;
            pushCyc("JAL", rndBit(), rndBit(), c);
            c = '0; c.regWrite = 1;
            pushCyc("ALUWB", rndBit(), rndBit(), c);
        end else begin
            c = '0; c.illegal = 1;
            for (int k = 0; k < 12; k++) pushCyc("ERROR", rndBit(), rndBit(), c);
        end
    endtask

    task automatic applyElem(input int i);
        MemReady = plan[i].ready;
        Zero     = plan[i].zero;
        expCtl   = plan[i].exp;
        expLabel = plan[i].label;
        expValid = 1'b1;
    endtask

    task automatic finishElem();
        @(posedge clk);
        #1;
    endtask

    task automatic startInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z, input int fw, input int mw);
        op = o; funct3 = f3; funct7b5 = f7;
        buildPlan(o, f3, f7, z, fw, mw);
        cur = 0;
        pending = 1'b0;
    endtask

    // Runs up to plan entry k and leaves it applied so literal checks can peek.
    task automatic goTo(input int k);
        if (pending) finishElem();
        for (int i = cur; i < k; i++) begin
            applyElem(i);
            finishElem();
        end
        applyElem(k);
        #2;
        cur = k + 1;
        pending = 1'b1;
    endtask

    task automatic endInstr();
        if (pending) finishElem();
        for (int i = cur; i < plan.size(); i++) begin
            applyElem(i);
            finishElem();
        end
        pending = 1'b0;
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input int fw, input int mw);
        startInstr(o, f3, f7, z, fw, mw);
        endInstr();
    endtask

    task automatic resetDut();
        expValid = 1'b0;
        MemReady = 1'b1;
        Zero     = 1'b1;
        reset    = 1'b0;
        #1;
        checkOutput("reset_strobes", {26'd0, MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Illegal}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [6:0] legalOps[6];
        logic [6:0] o;
        legalOps = '{OPC_LW, OPC_SW, OPC_R, OPC_I, OPC_BEQ, OPC_JAL};
        #2;
        resetDut();

        // lw with no waits: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
        startInstr(OPC_LW, 3'b000, 1'b0, 1'b0, 0, 0);
        goTo(0);
        checkOutput("fetch_memreq_after_release", {31'd0, MemReq}, 32'd1);
        goTo(3);
        checkOutput("lw_memread_regwrite", {31'd0, RegWrite}, 32'd0);
        goTo(4);
        checkOutput("lw_memwb_regwrite", {31'd0, RegWrite}, 32'd1);
        checkOutput("lw_memwb_resultsrc", {30'd0, ResultSrc}, 32'd1);
        endInstr();

        // sw held three cycles in MEMWRITE
        startInstr(OPC_SW, 3'b010, 1'b0, 1'b0, 0, 3);
        goTo(3);
        checkOutput("sw_wait_strobes", {29'd0, MemReq, MemWrite, AdrSrc}, 32'd7);
        goTo(6);
        checkOutput("sw_ready_strobes", {29'd0, MemReq, MemWrite, AdrSrc}, 32'd7);
        checkOutput("sw_regwrite", {31'd0, RegWrite}, 32'd0);
        endInstr();

        startInstr(OPC_R, 3'b000, 1'b1, 1'b0, 0, 0);
        goTo(2);
        checkOutput("r_sub_aluctl", {29'd0, ALUControl}, 32'd1);
        endInstr();
        startInstr(OPC_I, 3'b000, 1'b1, 1'b0, 0, 0);
        goTo(2);
        checkOutput("i_add_aluctl", {29'd0, ALUControl}, 32'd0);
        endInstr();
        startInstr(OPC_R, 3'b110, 1'b0, 1'b0, 0, 0);
        goTo(2);
        checkOutput("r_or_aluctl", {29'd0, ALUControl}, 32'd3);
        endInstr();

        startInstr(OPC_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        goTo(2);
        checkOutput("beq_taken_pcwrite", {31'd0, PCWrite}, 32'd1);
        endInstr();
        startInstr(OPC_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        goTo(2);
        checkOutput("beq_not_taken_pcwrite", {31'd0, PCWrite}, 32'd0);
        endInstr();

        // jal after two not-ready fetch cycles
        startInstr(OPC_JAL, 3'b000, 1'b0, 1'b0, 2, 0);
        goTo(1);
        checkOutput("jal_fetch_wait_irwrite", {31'd0, IRWrite}, 32'd0);
        goTo(2);
        checkOutput("jal_fetch_ready_irwrite", {31'd0, IRWrite}, 32'd1);
        goTo(4);
        checkOutput("jal_pcwrite", {31'd0, PCWrite}, 32'd1);
        checkOutput("jal_resultsrc", {30'd0, ResultSrc}, 32'd0);
        goTo(5);
        checkOutput("jal_aluwb_regwrite", {31'd0, RegWrite}, 32'd1);
        endInstr();

        // Unsupported opcode traps until reset
        startInstr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0);
        goTo(13);
        checkOutput("illegal_held", {31'd0, Illegal}, 32'd1);
        endInstr();
        resetDut();

        // Reset while a load is waiting on memory
        startInstr(OPC_LW, 3'b000, 1'b0, 1'b0, 0, 3);
        goTo(3);
        checkOutput("memread_req_before_reset", {31'd0, MemReq}, 32'd1);
        pending = 1'b0;
        resetDut();
        applyStimulus(OPC_R, 3'b111, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            o = legalOps[$urandom_range(0, 5)];
            applyStimulus(o, 3'($urandom_range(0, 7)), rndBit(), rndBit(),
                          $urandom_range(0, 2), $urandom_range(0, 3));
        end

        expValid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
